// File: rtl/pcie_rxcrdt_monitor.sv
// Receive-side PCIe credit monitor: decodes SOP headers on the completion and request
// streams, accumulates header/data credits, and rotates the counters out as credit words.
module pcie_rxcrdt_monitor #(
    parameter int          TDATA_WIDTH   = 512,
    parameter int unsigned CPL_HDR_INIT  = 256,
    parameter int unsigned CPL_DATA_INIT = 256,
    parameter int unsigned P_HDR_INIT    = 128,
    parameter int unsigned P_DATA_INIT   = 128,
    parameter int unsigned NP_HDR_INIT   = 128,
    parameter int unsigned NP_DATA_INIT  = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpld_tvalid,
    input  logic                   cpld_tready,
    input  logic                   cpld_tlast,
    input  logic [TDATA_WIDTH-1:0] cpld_tdata,
    input  logic                   req_tvalid,
    input  logic                   req_tready,
    input  logic                   req_tlast,
    input  logic [TDATA_WIDTH-1:0] req_tdata,
    output logic                   crdt_valid,
    input  logic                   crdt_ready,
    output logic [18:0]            crdt_data
);

    function automatic logic [8:0] f_credits(input logic [9:0] len);
        logic [10:0] sum;
        sum = {1'b0, len} + 11'd3;
        return (len == 10'd0) ? 9'd256 : sum[10:2];
    endfunction

    logic        r_cpl_sop, r_req_sop;
    logic        r_cpl_apply, r_req_apply;
    logic        r_pend_cplh, r_pend_ph, r_pend_nph;
    logic [8:0]  r_pend_cpld, r_pend_pd, r_pend_npd;
    logic [15:0] r_cnt_ph, r_cnt_nph, r_cnt_cplh, r_cnt_pd, r_cnt_npd, r_cnt_cpld;
    logic        r_crdt_valid;
    logic [18:0] r_crdt_data;

    logic        w_cpl_beat, w_req_beat;
    logic [7:0]  w_cpl_ft, w_req_ft;
    logic        w_cpl_is_cpl, w_cpl_has_data, w_req_posted, w_req_has_data;
    logic [8:0]  w_cpl_cr, w_req_cr;
    logic [2:0]  w_next_idx, w_load_idx;
    logic [15:0] w_sel_cnt;
    logic        w_unused_tdata;

    assign w_cpl_beat     = cpld_tvalid && cpld_tready;
    assign w_req_beat     = req_tvalid && req_tready;
    assign w_cpl_ft       = cpld_tdata[31:24];
    assign w_req_ft       = req_tdata[31:24];
    assign w_cpl_is_cpl   = (w_cpl_ft[4:0] == 5'b01010) || (w_cpl_ft[4:0] == 5'b01011);
    assign w_cpl_has_data = w_cpl_ft[6];
    assign w_req_has_data = w_req_ft[6];
    assign w_req_posted   = (w_req_ft == 8'h40) || (w_req_ft == 8'h60) || (w_req_ft[4:3] == 2'b10);
    assign w_cpl_cr       = f_credits(cpld_tdata[9:0]);
    assign w_req_cr       = f_credits(req_tdata[9:0]);
    assign w_unused_tdata = ^{cpld_tdata, req_tdata};

    // Rotation order 0,1,2,4,5,6; the very first word after reset shows the current index (0).
    always_comb begin
        w_next_idx = 3'd0;
        case (r_crdt_data[18:16])
            3'd0:    w_next_idx = 3'd1;
            3'd1:    w_next_idx = 3'd2;
            3'd2:    w_next_idx = 3'd4;
            3'd4:    w_next_idx = 3'd5;
            3'd5:    w_next_idx = 3'd6;
            default: w_next_idx = 3'd0;
        endcase
        w_load_idx = r_crdt_valid ? w_next_idx : r_crdt_data[18:16];
        w_sel_cnt  = 16'd0;
        case (w_load_idx)
            3'd0:    w_sel_cnt = r_cnt_ph;
            3'd1:    w_sel_cnt = r_cnt_nph;
            3'd2:    w_sel_cnt = r_cnt_cplh;
            3'd4:    w_sel_cnt = r_cnt_pd;
            3'd5:    w_sel_cnt = r_cnt_npd;
            3'd6:    w_sel_cnt = r_cnt_cpld;
            default: w_sel_cnt = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpl_sop    <= 1'b1;
            r_req_sop    <= 1'b1;
            r_cpl_apply  <= 1'b0;
            r_req_apply  <= 1'b0;
            r_pend_cplh  <= 1'b0;
            r_pend_ph    <= 1'b0;
            r_pend_nph   <= 1'b0;
            r_pend_cpld  <= 9'd0;
            r_pend_pd    <= 9'd0;
            r_pend_npd   <= 9'd0;
            r_cnt_ph     <= 16'(P_HDR_INIT);
            r_cnt_nph    <= 16'(NP_HDR_INIT);
            r_cnt_cplh   <= 16'(CPL_HDR_INIT);
            r_cnt_pd     <= 16'(P_DATA_INIT);
            r_cnt_npd    <= 16'(NP_DATA_INIT);
            r_cnt_cpld   <= 16'(CPL_DATA_INIT);
            r_crdt_valid <= 1'b0;
            r_crdt_data  <= 19'd0;
        end else begin
            if (w_cpl_beat)
                r_cpl_sop <= cpld_tlast;
            if (w_req_beat)
                r_req_sop <= req_tlast;

            if (w_cpl_beat && r_cpl_sop) begin
                r_pend_cplh <= w_cpl_is_cpl;
                r_pend_cpld <= (w_cpl_is_cpl && w_cpl_has_data) ? w_cpl_cr : 9'd0;
            end
            if (w_req_beat && r_req_sop) begin
                r_pend_ph  <= w_req_posted;
                r_pend_nph <= !w_req_posted;
                r_pend_pd  <= (w_req_posted && w_req_has_data) ? w_req_cr : 9'd0;
                r_pend_npd <= (!w_req_posted && w_req_has_data) ? w_req_cr : 9'd0;
            end

            // Pending values are consumed the cycle after tlast, so a new SOP may overwrite them then.
            r_cpl_apply <= w_cpl_beat && cpld_tlast;
            r_req_apply <= w_req_beat && req_tlast;

            if (r_cpl_apply) begin
                r_cnt_cplh <= r_cnt_cplh + {15'd0, r_pend_cplh};
                r_cnt_cpld <= r_cnt_cpld + {7'd0, r_pend_cpld};
            end
            if (r_req_apply) begin
                r_cnt_ph  <= r_cnt_ph  + {15'd0, r_pend_ph};
                r_cnt_nph <= r_cnt_nph + {15'd0, r_pend_nph};
                r_cnt_pd  <= r_cnt_pd  + {7'd0, r_pend_pd};
                r_cnt_npd <= r_cnt_npd + {7'd0, r_pend_npd};
            end

            if (!r_crdt_valid || crdt_ready) begin
                r_crdt_valid <= 1'b1;
                r_crdt_data  <= {w_load_idx, w_sel_cnt};
            end
        end
    end

    assign crdt_valid = r_crdt_valid;
    assign crdt_data  = r_crdt_data;

endmodule

// File: tb/tb_pcie_rxcrdt_monitor.sv
// Self-checking bench for pcie_rxcrdt_monitor: a spec-level credit model feeds a queue of
// expected credit words that is popped on every credit-word handshake.
module tb_pcie_rxcrdt_monitor;
    localparam int TW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpld_tvalid = 1'b0, cpld_tready = 1'b0, cpld_tlast = 1'b0;
    logic [TW-1:0] cpld_tdata = '0;
    logic          req_tvalid = 1'b0, req_tready = 1'b0, req_tlast = 1'b0;
    logic [TW-1:0] req_tdata = '0;
    logic          crdt_valid;
    logic          crdt_ready = 1'b0;
    logic [18:0]   crdt_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] m_cnt [0:7];
    logic [18:0] held_word;
    logic [2:0]  held_idx;
    logic [18:0] exp_q [$];

    pcie_rxcrdt_monitor #(.TDATA_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .cpld_tvalid(cpld_tvalid), .cpld_tready(cpld_tready), .cpld_tlast(cpld_tlast), .cpld_tdata(cpld_tdata),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tlast(req_tlast), .req_tdata(req_tdata),
        .crdt_valid(crdt_valid), .crdt_ready(crdt_ready), .crdt_data(crdt_data)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] nxt(input logic [2:0] i);
        case (i)
            3'd0:    return 3'd1;
            3'd1:    return 3'd2;
            3'd2:    return 3'd4;
            3'd4:    return 3'd5;
            3'd5:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    function automatic int pos(input logic [2:0] i);
        case (i)
            3'd0:    return 0;
            3'd1:    return 1;
            3'd2:    return 2;
            3'd4:    return 3;
            3'd5:    return 4;
            default: return 5;
        endcase
    endfunction

    task automatic model_init();
        for (int i = 0; i < 8; i++) m_cnt[i] = 16'd0;
        m_cnt[0] = 16'd128; m_cnt[1] = 16'd128; m_cnt[2] = 16'd256;
        m_cnt[4] = 16'd128; m_cnt[5] = 16'd128; m_cnt[6] = 16'd256;
        held_idx  = 3'd0;
        held_word = {3'd0, 16'd128};
    endtask

    task automatic model_pkt(input bit is_req, input logic [31:0] hdr);
        logic [7:0]  ft;
        logic [15:0] cr;
        ft = hdr[31:24];
        cr = (hdr[9:0] == 10'd0) ? 16'd256 : 16'((int'(hdr[9:0]) + 3) / 4);
        if (!is_req) begin
            if (ft[4:0] == 5'h0A || ft[4:0] == 5'h0B) begin
                m_cnt[2] = m_cnt[2] + 16'd1;
                if (ft[6]) m_cnt[6] = m_cnt[6] + cr;
            end
        end else if (ft == 8'h40 || ft == 8'h60 || ft[4:3] == 2'b10) begin
            m_cnt[0] = m_cnt[0] + 16'd1;
            if (ft[6]) m_cnt[4] = m_cnt[4] + cr;
        end else begin
            m_cnt[1] = m_cnt[1] + 16'd1;
            if (ft[6]) m_cnt[5] = m_cnt[5] + cr;
        end
    endtask

    task automatic send_pkt(input bit is_req, input logic [31:0] hdr, input int nb);
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            // Non-SOP beats carry a CplD-looking pattern that must not be decoded.
            if (is_req) begin
                req_tvalid = 1'b1; req_tready = 1'b1; req_tlast = (b == nb - 1);
                req_tdata = '0; req_tdata[31:0] = (b == 0) ? hdr : 32'h4A00_0010;
            end else begin
                cpld_tvalid = 1'b1; cpld_tready = 1'b1; cpld_tlast = (b == nb - 1);
                cpld_tdata = '0; cpld_tdata[31:0] = (b == 0) ? hdr : 32'h4A00_0010;
            end
        end
        @(negedge clk);
        req_tvalid = 1'b0; req_tlast = 1'b0; cpld_tvalid = 1'b0; cpld_tlast = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    // Pushes the words expected from n handshakes, then accepts and compares them.
    task automatic drain(input int n);
        logic [2:0]  i;
        logic [18:0] exp;
        exp_q.push_back(held_word);
        i = held_idx;
        for (int k = 1; k < n; k++) begin
            i = nxt(i);
            exp_q.push_back({i, m_cnt[i]});
        end
        i = nxt(i);
        held_idx  = i;
        held_word = {i, m_cnt[i]};
        @(negedge clk);
        crdt_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            exp = exp_q.pop_front();
            total_cnt++;
            if (crdt_valid !== 1'b1 || crdt_data !== exp)
                $display("FAIL credit_word[%0d]: got valid=%b data=%h, expected valid=1 data=%h", k, crdt_valid, crdt_data, exp);
            else
                pass_cnt++;
            @(negedge clk);
        end
        crdt_ready = 1'b0;
    endtask

    task automatic drain_to(input logic [2:0] target);
        int n;
        n = (pos(target) - pos(held_idx) + 6) % 6;
        if (n == 0) n = 6;
        drain(n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; crdt_ready = 1'b0;
        cpld_tvalid = 1'b0; cpld_tlast = 1'b0; req_tvalid = 1'b0; req_tlast = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_init();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; crdt_ready = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (crdt_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", crdt_valid);
        else pass_cnt++;
        total_cnt++;
        if (crdt_data !== 19'd0) $display("FAIL reset_data: got %h, expected 0", crdt_data);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (crdt_valid !== 1'b1 || crdt_data !== {3'd0, 16'd128})
            $display("FAIL first_word: got valid=%b data=%h, expected valid=1 data=%h", crdt_valid, crdt_data, {3'd0, 16'd128});
        else pass_cnt++;
        model_init();
        drain(7);
    endtask

    task automatic test_cpl();
        send_pkt(1'b0, 32'h4A00_0010, 1); model_pkt(1'b0, 32'h4A00_0010);
        send_pkt(1'b0, 32'h0A00_0000, 1); model_pkt(1'b0, 32'h0A00_0000);
        send_pkt(1'b0, 32'h4B00_0000, 3); model_pkt(1'b0, 32'h4B00_0000);
        send_pkt(1'b0, 32'h4000_0004, 1); model_pkt(1'b0, 32'h4000_0004);
        settle();
        drain(6);
    endtask

    task automatic test_req();
        send_pkt(1'b1, 32'h4000_0005, 3); model_pkt(1'b1, 32'h4000_0005);
        send_pkt(1'b1, 32'h2000_0001, 1); model_pkt(1'b1, 32'h2000_0001);
        send_pkt(1'b1, 32'h6000_0000, 2); model_pkt(1'b1, 32'h6000_0000);
        send_pkt(1'b1, 32'h3000_0000, 1); model_pkt(1'b1, 32'h3000_0000);
        send_pkt(1'b1, 32'h7000_0002, 1); model_pkt(1'b1, 32'h7000_0002);
        send_pkt(1'b1, 32'h4200_0001, 1); model_pkt(1'b1, 32'h4200_0001);
        settle();
        drain(6);
    endtask

    task automatic test_timing();
        logic [18:0] exp;
        drain_to(3'd6);
        @(negedge clk);
        req_tvalid = 1'b1; req_tready = 1'b1; req_tlast = 1'b1;
        req_tdata = '0; req_tdata[31:0] = 32'h4000_0004;
        @(negedge clk);
        req_tvalid = 1'b0; req_tlast = 1'b0; crdt_ready = 1'b1;
        @(negedge clk);
        crdt_ready = 1'b0;
        exp = {3'd0, m_cnt[0]};
        total_cnt++;
        if (crdt_data !== exp) $display("FAIL timing_pre_update: got %h, expected %h", crdt_data, exp);
        else pass_cnt++;
        model_pkt(1'b1, 32'h4000_0004);
        held_idx = 3'd0; held_word = exp;
        settle();
        drain_to(3'd6);
        @(negedge clk);
        req_tvalid = 1'b1; req_tready = 1'b1; req_tlast = 1'b1;
        req_tdata = '0; req_tdata[31:0] = 32'h4000_0004;
        @(negedge clk);
        req_tvalid = 1'b0; req_tlast = 1'b0;
        @(negedge clk);
        crdt_ready = 1'b1;
        @(negedge clk);
        crdt_ready = 1'b0;
        model_pkt(1'b1, 32'h4000_0004);
        exp = {3'd0, m_cnt[0]};
        total_cnt++;
        if (crdt_data !== exp) $display("FAIL timing_post_update: got %h, expected %h", crdt_data, exp);
        else pass_cnt++;
        held_idx = 3'd0; held_word = exp;
        settle();
        drain(6);
    endtask

    task automatic test_hold();
        drain_to(3'd6);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) begin
                cpld_tvalid = 1'b1; cpld_tready = 1'b1; cpld_tlast = 1'b1;
                cpld_tdata = '0; cpld_tdata[31:0] = 32'h4A00_0008;
            end else begin
                cpld_tvalid = 1'b0; cpld_tlast = 1'b0;
            end
            total_cnt++;
            if (crdt_valid !== 1'b1 || crdt_data !== held_word)
                $display("FAIL hold_stable[%0d]: got valid=%b data=%h, expected valid=1 data=%h", c, crdt_valid, crdt_data, held_word);
            else pass_cnt++;
        end
        model_pkt(1'b0, 32'h4A00_0008);
        settle();
        drain(7);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cpld_tvalid = 1'b1; cpld_tready = 1'b0; cpld_tlast = 1'b1;
        cpld_tdata = '0; cpld_tdata[31:0] = 32'h4A00_0040;
        req_tvalid = 1'b0; req_tready = 1'b1; req_tlast = 1'b1;
        req_tdata = '0; req_tdata[31:0] = 32'h4000_0040;
        @(negedge clk);
        cpld_tvalid = 1'b1; cpld_tready = 1'b1; cpld_tdata[31:0] = 32'h4A00_0004;
        req_tvalid = 1'b1; req_tready = 1'b1; req_tdata[31:0] = 32'h4000_0008;
        @(negedge clk);
        cpld_tdata[31:0] = 32'h0A00_0000;
        req_tdata[31:0]  = 32'h2000_0000;
        @(negedge clk);
        cpld_tvalid = 1'b0; cpld_tlast = 1'b0; req_tvalid = 1'b0; req_tlast = 1'b0;
        model_pkt(1'b0, 32'h4A00_0004); model_pkt(1'b1, 32'h4000_0008);
        model_pkt(1'b0, 32'h0A00_0000); model_pkt(1'b1, 32'h2000_0000);
        settle();
        drain(6);
    endtask

    task automatic test_reset_midpacket();
        @(negedge clk);
        req_tvalid = 1'b1; req_tready = 1'b1; req_tlast = 1'b0;
        req_tdata = '0; req_tdata[31:0] = 32'h4000_0005;
        cpld_tvalid = 1'b1; cpld_tready = 1'b1; cpld_tlast = 1'b0;
        cpld_tdata = '0; cpld_tdata[31:0] = 32'h4A00_0010;
        @(negedge clk);
        req_tdata[31:0] = 32'h0000_0000;
        cpld_tdata[31:0] = 32'h0000_0000;
        do_reset();
        send_pkt(1'b1, 32'h2000_0001, 1); model_pkt(1'b1, 32'h2000_0001);
        send_pkt(1'b0, 32'h0A00_0000, 1); model_pkt(1'b0, 32'h0A00_0000);
        settle();
        drain(6);
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        cpld_tvalid = 1'b1; cpld_tready = 1'b1; cpld_tlast = 1'b1;
        cpld_tdata = '0; cpld_tdata[31:0] = 32'h0A00_0000;
        repeat (65535) @(negedge clk);
        cpld_tvalid = 1'b0; cpld_tlast = 1'b0;
        m_cnt[2] = 16'd255;
        settle();
        drain(6);
    endtask

    initial begin
        model_init();
        test_reset();
        test_cpl();
        test_req();
        test_timing();
        test_hold();
        test_back_to_back();
        test_reset_midpacket();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
